// File: rtl/i2c_reg_target.sv
// I2C register target: oversampled SCL/SDA, open-drain SDA, 2**REG_AW x 8 register file
// written by [dev, sub, data...] transfers and read back via repeated-START random reads.

module i2c_line_filt #(
  parameter int FILT = 3
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iPIN,
  output logic oLINE
);
  localparam int CW = $clog2(FILT + 1);
  logic          r_s1, r_s2, r_line;
  logic [CW-1:0] r_cnt;

  // The filtered line follows the pin only after FILT consecutive differing samples.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_line <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_s1 <= iPIN;
      r_s2 <= r_s1;
      if (r_s2 != r_line) begin
        if (r_cnt == CW'(FILT - 1)) begin
          r_line <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign oLINE = r_line;
endmodule

module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         REG_AW   = 6,
  parameter int         FILT     = 3
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSCL,
  input  logic              iSDA,
  output logic              oSDA_OE,
  output logic              oWR_STB,
  output logic [REG_AW-1:0] oWR_ADDR,
  output logic [7:0]        oWR_DATA,
  input  logic [REG_AW-1:0] iRD_ADDR,
  output logic [7:0]        oRD_DATA,
  output logic              oBUSY
);
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [2:0] {IDLE, DEV, SUB, WDATA, RDATA, ACK, MACK, IGNORE} state_t;

  logic [1:0]        w_line;
  logic              w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic [7:0]        w_byte;
  logic              r_scl_d, r_sda_d;
  state_t            r_state, r_next;
  logic [3:0]        r_bitcnt;
  logic [7:0]        r_sh;
  logic [REG_AW-1:0] r_ptr;
  logic              r_ackph, r_oe, r_wr_stb;
  logic [REG_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data, r_rd_data;
  logic [7:0]        r_mem [NUM_REGS];

  i2c_line_filt #(.FILT(FILT)) u_filt [1:0] (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iPIN  ({iSCL, iSDA}),
    .oLINE (w_line)
  );

  assign w_scl   = w_line[1];
  assign w_sda   = w_line[0];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop  = ~r_sda_d & w_sda & w_scl & r_scl_d;
  assign w_byte  = {r_sh[6:0], w_sda};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_state   <= IDLE;
      r_next    <= IDLE;
      r_bitcnt  <= '0;
      r_sh      <= '0;
      r_ptr     <= '0;
      r_ackph   <= 1'b0;
      r_oe      <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
      r_wr_stb <= 1'b0;
      if (w_start) begin
        r_state  <= DEV;
        r_bitcnt <= '0;
        r_ackph  <= 1'b0;
        r_oe     <= 1'b0;
      end else if (w_stop) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          DEV, SUB, WDATA: if (w_rise) begin
            r_sh     <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= '0;
              r_ackph  <= 1'b0;
              r_state  <= ACK;
              case (r_state)
                DEV: begin
                  if (w_byte[7:1] != DEV_ADDR) r_state <= IGNORE;
                  r_next <= w_byte[0] ? RDATA : SUB;
                end
                SUB: begin
                  r_ptr  <= w_byte[REG_AW-1:0];
                  r_next <= WDATA;
                end
                default: begin
                  r_mem[r_ptr] <= w_byte;
                  r_wr_stb     <= 1'b1;
                  r_wr_addr    <= r_ptr;
                  r_wr_data    <= w_byte;
                  r_ptr        <= r_ptr + 1'b1;
                  r_next       <= WDATA;
                end
              endcase
            end
          end
          // First fall pulls SDA low for the ACK bit, second fall ends it.
          ACK: if (w_fall) begin
            if (!r_ackph) begin
              r_oe    <= 1'b1;
              r_ackph <= 1'b1;
            end else begin
              r_ackph  <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= r_next;
              if (r_next == RDATA) begin
                r_sh <= r_mem[r_ptr];
                r_oe <= ~r_mem[r_ptr][7];
              end else begin
                r_oe <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (w_rise) r_bitcnt <= r_bitcnt + 4'd1;
            if (w_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_oe    <= 1'b0;
                r_state <= MACK;
              end else begin
                r_sh <= {r_sh[6:0], r_sh[7]};
                r_oe <= ~r_sh[6];
              end
            end
          end
          MACK: begin
            if (w_rise) begin
              if (!w_sda) begin
                r_ptr   <= r_ptr + 1'b1;
                r_ackph <= 1'b1;
              end else begin
                r_state <= IGNORE;
              end
            end else if (w_fall && r_ackph) begin
              r_ackph  <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= RDATA;
              r_sh     <= r_mem[r_ptr];
              r_oe     <= ~r_mem[r_ptr][7];
            end
          end
          default: r_oe <= 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) r_rd_data <= '0;
    else      r_rd_data <= r_mem[iRD_ADDR];
  end

  assign oSDA_OE  = r_oe;
  assign oWR_STB  = r_wr_stb;
  assign oWR_ADDR = r_wr_addr;
  assign oWR_DATA = r_wr_data;
  assign oRD_DATA = r_rd_data;
  assign oBUSY    = r_state inside {SUB, WDATA, RDATA, ACK, MACK};
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, array-based register model,
// table of single-byte writes, hand sequences for corner cases, random traffic.

module tb_i2c_reg_target;
  localparam int Q = 8;

  logic       clk = 1'b0, rst = 1'b1, mscl = 1'b1, msda = 1'b1;
  logic [5:0] rd_addr = '0;
  logic       oe, wr_stb, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, rd_data;
  logic       sda_bus;

  assign sda_bus = msda & ~oe;
  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(7'h1A), .REG_AW(6), .FILT(3)) dut (
    .iCLK(clk), .iRST(rst), .iSCL(mscl), .iSDA(sda_bus), .oSDA_OE(oe),
    .oWR_STB(wr_stb), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oBUSY(busy)
  );

  typedef struct { logic [5:0] a; logic [7:0] d; } stb_t;
  typedef struct { logic [7:0] dev, sub, dat; logic ack; logic [5:0] ridx; logic [7:0] rexp; } vec_t;

  int   checks = 0, errors = 0;
  stb_t stb_q[$];
  logic busy_seen = 1'b0, oe_seen = 1'b0;
  logic [7:0] mem_m [64];
  int   ptr_m = 0;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_t s;
      s.a = wr_addr;
      s.d = wr_data;
      stb_q.push_back(s);
    end
    if (busy) busy_seen = 1'b1;
    if (oe)   oe_seen   = 1'b1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    msda = b; tick(Q);
    mscl = 1'b1; tick(Q);
    r = sda_bus; tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    msda = 1'b1; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b0; tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    msda = 1'b0; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b1; tick(Q);
  endtask

  task automatic byte_tx(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask

  task automatic byte_rx(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(~mack, r);
  endtask

  task automatic host_rd(input logic [5:0] idx, output logic [7:0] d);
    @(negedge clk);
    rd_addr = idx;
    @(posedge clk);
    #1 d = rd_data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
  endtask

  task automatic do_write(input logic [7:0] dev, input logic [7:0] sub,
                          input logic [7:0] d [4], input int n);
    logic a, m;
    stb_t exp_q[$];
    m = (dev[7:1] == 7'h1A);
    stb_q.delete();
    busy_seen = 1'b0;
    i2c_start();
    byte_tx(dev, a); chk("dev_ack", a, m);
    byte_tx(sub, a); chk("sub_ack", a, m);
    if (m) ptr_m = sub % 64;
    for (int i = 0; i < n; i++) begin
      byte_tx(d[i], a); chk("dat_ack", a, m);
      if (m) begin
        stb_t s;
        s.a = 6'(ptr_m);
        s.d = d[i];
        exp_q.push_back(s);
        mem_m[ptr_m] = d[i];
        ptr_m = (ptr_m + 1) % 64;
      end
    end
    chk("busy_mid", busy, m);
    i2c_stop(); tick(4);
    chk("busy_seen", busy_seen, m);
    chk("stb_cnt", stb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++) begin
      chk("stb_addr", stb_q[i].a, exp_q[i].a);
      chk("stb_data", stb_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic do_read(input logic use_sub, input logic [7:0] sub, input int n,
                         output logic [7:0] got [4]);
    logic a;
    stb_q.delete();
    i2c_start();
    if (use_sub) begin
      byte_tx(8'h34, a); chk("rd_wdev_ack", a, 1);
      byte_tx(sub, a);   chk("rd_sub_ack", a, 1);
      ptr_m = sub % 64;
      i2c_start();
    end
    byte_tx(8'h35, a); chk("rd_dev_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      byte_rx(i < n - 1, got[i]);
      chk("rd_data", got[i], mem_m[ptr_m]);
      if (i < n - 1) ptr_m = (ptr_m + 1) % 64;
    end
    chk("oe_after_nack", oe, 0);
    chk("busy_after_nack", busy, 0);
    i2c_stop(); tick(4);
    chk("rd_no_stb", stb_q.size(), 0);
  endtask

  initial begin
    vec_t       tbl [5];
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] v;
    logic       r, a;

    tbl[0] = '{8'h34, 8'h05, 8'h0A, 1'b1, 6'd5,  8'h0A};
    tbl[1] = '{8'h72, 8'h05, 8'hFF, 1'b0, 6'd5,  8'h0A};
    tbl[2] = '{8'h34, 8'h45, 8'h5C, 1'b1, 6'd5,  8'h5C};
    tbl[3] = '{8'h36, 8'h07, 8'h11, 1'b0, 6'd7,  8'h00};
    tbl[4] = '{8'h34, 8'h3F, 8'hC3, 1'b1, 6'd63, 8'hC3};
    model_reset();
    d[0] = 0; d[1] = 0; d[2] = 0; d[3] = 0;

    // reset state
    tick(5);
    @(posedge clk); #1;
    chk("rst_oe", oe, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk); rst = 1'b0;
    tick(10);

    // table of single-byte writes
    for (int k = 0; k < 5; k++) begin
      d[0] = tbl[k].dat;
      do_write(tbl[k].dev, tbl[k].sub, d, 1);
      chk("tbl_busy", busy_seen, tbl[k].ack);
      host_rd(tbl[k].ridx, v);
      chk("tbl_rd", v, tbl[k].rexp);
      chk("tbl_rd_model", v, mem_m[tbl[k].ridx]);
    end

    // burst across the top of the register file
    d[0] = 8'h11; d[1] = 8'h22;
    do_write(8'h34, 8'h3F, d, 2);
    host_rd(6'd63, v); chk("wrap_63", v, 8'h11);
    host_rd(6'd0, v);  chk("wrap_0", v, 8'h22);

    // random read: ACK then NACK
    d[0] = 8'hA5; d[1] = 8'h3C;
    do_write(8'h34, 8'h03, d, 2);
    do_read(1'b1, 8'h03, 2, got);
    chk("rd_byte0", got[0], 8'hA5);
    chk("rd_byte1", got[1], 8'h3C);

    // sub-filter glitches on SCL while SDA toggles
    stb_q.delete();
    i2c_start();
    byte_tx(8'h34, a);
    byte_tx(8'h09, a);
    for (int g = 0; g < 4; g++) begin
      msda = g[0]; tick(3);
      mscl = 1'b1; tick(2);
      mscl = 1'b0; tick(3);
      msda = ~msda; tick(4);
    end
    chk("glitch_busy", busy, 1);
    chk("glitch_nostb", stb_q.size(), 0);
    byte_tx(8'h6E, a); chk("glitch_ack", a, 1);
    i2c_stop(); tick(4);
    mem_m[9] = 8'h6E; ptr_m = 10;
    chk("glitch_stb_cnt", stb_q.size(), 1);
    if (stb_q.size() > 0) begin
      chk("glitch_stb_addr", stb_q[0].a, 9);
      chk("glitch_stb_data", stb_q[0].d, 8'h6E);
    end

    // reset in the middle of a driven read byte
    d[0] = 8'h00;
    do_write(8'h34, 8'h07, d, 1);
    i2c_start();
    byte_tx(8'h34, a);
    byte_tx(8'h07, a);
    i2c_start();
    byte_tx(8'h35, a);
    for (int i = 0; i < 3; i++) bit_io(1'b1, r);
    chk("oe_before_rst", oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_oe", oe, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    oe_seen = 1'b0;
    stb_q.delete();
    for (int i = 0; i < 6; i++) bit_io(1'b1, r);
    i2c_stop(); tick(4);
    chk("rst_no_ack", oe_seen, 0);
    chk("rst_no_stb", stb_q.size(), 0);
    model_reset();
    host_rd(6'd5, v);  chk("rst_reg5", v, 0);
    host_rd(6'd63, v); chk("rst_reg63", v, 0);
    d[0] = 8'h0A;
    do_write(8'h34, 8'h05, d, 1);
    host_rd(6'd5, v); chk("post_rst_rd", v, 8'h0A);

    // random traffic against the model
    for (int t = 0; t < 12; t++) begin
      int kind, n;
      logic [7:0] dev;
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (kind == 0) begin
        dev = ($urandom_range(0, 5) == 0) ? {7'h1A ^ 7'($urandom_range(1, 127)), 1'b0} : 8'h34;
        do_write(dev, 8'($urandom), d, n);
      end else begin
        do_read(kind == 1, 8'($urandom), n, got);
      end
    end

    for (int i = 0; i < 64; i++) begin
      host_rd(6'(i), v);
      chk("final_reg", v, mem_m[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
